// File: rtl/ysyx_041461_axi_burst_ram.sv
// AXI4 slave burst RAM: single-port array shared by read and write channels, FIXED/INCR/WRAP bursts.
// Optional out-of-range error responses when YSYX_041461_AXI_RAM_ERR_EN is defined.
module ysyx_041461_axi_burst_ram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_W-1:0]     rid,
    output logic [1:0]          rresp,
    output logic [DATA_W-1:0]   rdata,
    output logic                rlast
);

    localparam int NB     = DATA_W / 8;
    localparam int LOG_NB = $clog2(NB);
    localparam int LOG_D  = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_e;
    typedef enum logic {RR_READ, RR_WRITE} rr_e;

    state_e              state_q, state_d;
    rr_e                 rr_q, rr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                bvalid_q, bvalid_d;
    logic [ID_W-1:0]     bid_q, bid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [ID_W-1:0]     rid_q, rid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rlast_q, rlast_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_load;
    logic                wr_oob;
    logic                rd_oob;
    logic [ADDR_W-1:0]   nxt_addr;

    // Oversized beats step by the bus width; WRAP with an illegal length degrades to INCR.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [2:0]        eff;
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        eff  = (size > 3'(LOG_NB)) ? 3'(LOG_NB) : size;
        step = ADDR_W'(1) << eff;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << eff) - ADDR_W'(1);
        next_addr = addr + step;
        if (burst == 2'b00) begin
            next_addr = addr;
        end else if (burst == 2'b10 &&
                     (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            next_addr = (addr & ~mask) | ((addr + step) & mask);
        end
    endfunction

`ifdef YSYX_041461_AXI_RAM_ERR_EN
    assign wr_oob = |addr_q[ADDR_W-1:LOG_NB+LOG_D];
    assign rd_oob = |rd_addr[ADDR_W-1:LOG_NB+LOG_D];
`else
    assign wr_oob = 1'b0;
    assign rd_oob = 1'b0;
`endif

    assign nxt_addr = next_addr(addr_q, len_q, size_q, burst_q);

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        rlast_d  = rlast_q;
        awready  = 1'b0;
        arready  = 1'b0;
        wready   = 1'b0;
        mem_we   = 1'b0;
        rd_addr  = addr_q;
        rd_load  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Round-robin on simultaneous requests; rr_q holds the last channel granted.
                awready = awvalid & (~arvalid | (rr_q == RR_READ));
                arready = arvalid & (~awvalid | (rr_q == RR_WRITE));
                if (awready) begin
                    state_d = S_WDATA;
                    rr_d    = RR_WRITE;
                    id_d    = awid;
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                end else if (arready) begin
                    state_d  = S_RDATA;
                    rr_d     = RR_READ;
                    addr_d   = araddr;
                    len_d    = arlen;
                    size_d   = arsize;
                    burst_d  = arburst;
                    cnt_d    = 8'd0;
                    rd_addr  = araddr;
                    rd_load  = 1'b1;
                    rvalid_d = 1'b1;
                    rid_d    = arid;
                    rlast_d  = (arlen == 8'd0);
                end
            end
            S_WDATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = ~wr_oob;
                    err_d  = err_q | wr_oob;
                    addr_d = nxt_addr;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        state_d  = S_WRESP;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = (err_q | wr_oob) ? 2'b10 : 2'b00;
                    end
                end
            end
            S_WRESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_RDATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        addr_d  = nxt_addr;
                        rd_addr = nxt_addr;
                        rd_load = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The next beat is fetched on the same edge that retires the current one.
        if (rd_load) begin
            rdata_d = rd_oob ? '0 : mem[rd_addr[LOG_NB +: LOG_D]];
            rresp_d = rd_oob ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= RR_READ;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rresp_q  <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
        end
    end

    // The array has no reset so contents survive an aborted burst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[addr_q[LOG_NB +: LOG_D]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign bvalid = bvalid_q;
    assign bid    = bid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;
    assign rlast  = rlast_q;

endmodule

// File: tb/tb_ysyx_041461_axi_burst_ram.sv
// Directed bench for ysyx_041461_axi_burst_ram: read-burst vector table plus hand-written
// arbitration, stall, strobe, aliasing/error and mid-burst reset sequences.
module tb_ysyx_041461_axi_burst_ram;

    logic        clk;
    logic        rst_n;
    logic        awvalid, awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        rlast;

`ifdef YSYX_041461_AXI_RAM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    ysyx_041461_axi_burst_ram dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp),
        .rdata(rdata), .rlast(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    logic [63:0] rbuf [16];
    logic        rlbuf [16];
    logic [1:0]  rrbuf [16];
    logic [3:0]  ridFirst;
    int          rcount;
    int          rcycles;
    int          stallBad;

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0][63:0] exp;
    } rvec_t;

    function automatic rvec_t mkVec(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                    input logic [1:0] b, input logic [63:0] e0, input logic [63:0] e1,
                                    input logic [63:0] e2, input logic [63:0] e3);
        rvec_t v;
        v.addr = a; v.len = l; v.size = s; v.burst = b;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus();
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    endtask

    task automatic doReset();
        applyStimulus();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic sendAw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] id);
        bit ok = 0;
        awvalid = 1; awaddr = a; awlen = l; awsize = s; awburst = b; awid = id;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = awready;
            @(posedge clk); #1;
        end
        awvalid = 0;
        if (!ok) checkOutput("aw_timeout", 0, 1);
    endtask

    task automatic sendAr(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] id);
        bit ok = 0;
        arvalid = 1; araddr = a; arlen = l; arsize = s; arburst = b; arid = id;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = arready;
            @(posedge clk); #1;
        end
        arvalid = 0;
        if (!ok) checkOutput("ar_timeout", 0, 1);
    endtask

    task automatic sendW(input int n);
        for (int k = 0; k < n; k++) begin
            bit ok = 0;
            wvalid = 1; wdata = wbuf[k]; wstrb = sbuf[k]; wlast = (k == n - 1);
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk); ok = wready;
                @(posedge clk); #1;
            end
            if (!ok) checkOutput("w_timeout", 0, 1);
        end
        wvalid = 0; wlast = 0;
    endtask

    task automatic getB(input logic [1:0] expResp, input logic [3:0] expId, input string tag);
        bit          ok = 0;
        logic [1:0]  resp = 0;
        logic [3:0]  idv = 0;
        checkOutput({tag, "_bvalid_latency"}, bvalid, 1);
        bready = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = bvalid; resp = bresp; idv = bid;
            @(posedge clk); #1;
        end
        bready = 0;
        if (!ok) checkOutput({tag, "_b_timeout"}, 0, 1);
        checkOutput({tag, "_bresp"}, resp, expResp);
        checkOutput({tag, "_bid"}, idv, expId);
        checkOutput({tag, "_bvalid_drop"}, bvalid, 0);
    endtask

    task automatic writeBurst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] expResp,
                              input string tag);
        sendAw(a, l, 3'd3, 2'd1, 4'd7);
        sendW(int'(l) + 1);
        getB(expResp, 4'd7, tag);
    endtask

    task automatic recvR(input int n, input bit toggle);
        bit          prevStall = 0;
        logic [63:0] prevData = 0;
        logic        prevLast = 0;
        rcount = 0; rcycles = 0; stallBad = 0;
        for (int cyc = 0; cyc < 64 && rcount < n; cyc++) begin
            rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            if (prevStall && (rdata !== prevData || rlast !== prevLast || !rvalid)) stallBad++;
            if (rvalid && rready) begin
                if (rcount == 0) ridFirst = rid;
                rbuf[rcount] = rdata; rlbuf[rcount] = rlast; rrbuf[rcount] = rresp;
                rcount++;
            end
            prevStall = rvalid && !rready; prevData = rdata; prevLast = rlast;
            @(posedge clk); #1;
            rcycles = cyc + 1;
        end
        rready = 0;
        if (rcount < n) checkOutput("r_timeout", rcount, n);
    endtask

    task automatic readBurst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b);
        sendAr(a, l, s, b, 4'd9);
        recvR(int'(l) + 1, 1'b0);
    endtask

    rvec_t vecs [8];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_bvalid", bvalid, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_wready", wready, 0);
        checkOutput("rst_rlast", rlast, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_resp", {bresp, rresp, bid, rid}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 64'h11 * (i + 1); sbuf[i] = 8'hFF;
        end
        writeBurst(32'h100, 8'd3, 2'b00, "incr_wr");

        vecs[0] = mkVec(32'h100, 8'd3, 3'd3, 2'd1, 64'h11, 64'h22, 64'h33, 64'h44);
        vecs[1] = mkVec(32'h118, 8'd3, 3'd3, 2'd2, 64'h44, 64'h11, 64'h22, 64'h33);
        vecs[2] = mkVec(32'h108, 8'd2, 3'd3, 2'd0, 64'h22, 64'h22, 64'h22, 64'h0);
        vecs[3] = mkVec(32'h108, 8'd1, 3'd3, 2'd2, 64'h22, 64'h11, 64'h0, 64'h0);
        vecs[4] = mkVec(32'h100, 8'd3, 3'd2, 2'd1, 64'h11, 64'h11, 64'h22, 64'h22);
        vecs[5] = mkVec(32'h110, 8'd1, 3'd7, 2'd1, 64'h33, 64'h44, 64'h0, 64'h0);
        vecs[6] = mkVec(32'h108, 8'd2, 3'd3, 2'd2, 64'h22, 64'h33, 64'h44, 64'h0);
        vecs[7] = mkVec(32'h104, 8'd3, 3'd2, 2'd2, 64'h11, 64'h22, 64'h22, 64'h11);

        for (int v = 0; v < 8; v++) begin
            readBurst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
            checkOutput($sformatf("v%0d_count", v), rcount, int'(vecs[v].len) + 1);
            for (int b = 0; b <= int'(vecs[v].len); b++) begin
                checkOutput($sformatf("v%0d_b%0d_data", v, b), rbuf[b], vecs[v].exp[b]);
                checkOutput($sformatf("v%0d_b%0d_rlast", v, b), rlbuf[b], b == int'(vecs[v].len));
                checkOutput($sformatf("v%0d_b%0d_rresp", v, b), rrbuf[b], 0);
            end
            checkOutput($sformatf("v%0d_rid", v), ridFirst, 4'd9);
            checkOutput($sformatf("v%0d_rvalid_drop", v), rvalid, 0);
        end

        wbuf[0] = 64'hFFFFFFFF_FFFFFFFF; sbuf[0] = 8'hFF;
        writeBurst(32'h300, 8'd0, 2'b00, "strb_fill");
        wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
        writeBurst(32'h300, 8'd0, 2'b00, "strb_part");
        readBurst(32'h300, 8'd0, 3'd3, 2'd1);
        checkOutput("strb_data", rbuf[0], 64'hFFFFFFFF_00000000);

        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 64'hC0DE_0000 + 64'(i); sbuf[i] = 8'hFF;
        end
        writeBurst(32'h400, 8'd7, 2'b00, "tog_wr");
        sendAr(32'h400, 8'd7, 3'd3, 2'd1, 4'd2);
        recvR(8, 1'b1);
        checkOutput("tog_count", rcount, 8);
        checkOutput("tog_stable", stallBad, 0);
        checkOutput("tog_cycles", (rcycles >= 15 && rcycles <= 16), 1);
        for (int b = 0; b < 8; b++) begin
            checkOutput($sformatf("tog_b%0d_data", b), rbuf[b], 64'hC0DE_0000 + 64'(b));
            checkOutput($sformatf("tog_b%0d_rlast", b), rlbuf[b], b == 7);
        end

        wbuf[0] = 64'h5555; sbuf[0] = 8'hFF;
        writeBurst(32'h0, 8'd0, 2'b00, "oob_base");
        wbuf[0] = 64'hDEAD;
        writeBurst(32'h8000, 8'd0, ERR ? 2'b10 : 2'b00, "oob_wr");
        readBurst(32'h0, 8'd0, 3'd3, 2'd1);
        checkOutput("oob_word0", rbuf[0], ERR ? 64'h5555 : 64'hDEAD);
        checkOutput("oob_word0_rresp", rrbuf[0], 0);
        readBurst(32'h8000, 8'd0, 3'd3, 2'd1);
        checkOutput("oob_rd_data", rbuf[0], ERR ? 64'h0 : 64'hDEAD);
        checkOutput("oob_rd_rresp", rrbuf[0], ERR ? 2'b10 : 2'b00);

        doReset();
        awvalid = 1; awaddr = 32'h500; awlen = 0; awsize = 3; awburst = 1; awid = 4'd3;
        arvalid = 1; araddr = 32'h100; arlen = 0; arsize = 3; arburst = 1; arid = 4'd5;
        wbuf[0] = 64'hAB; sbuf[0] = 8'hFF;
        for (int t = 0; t < 4; t++) begin
            int g;
            @(negedge clk);
            g = awready ? 1 : (arready ? 2 : 0);
            @(posedge clk); #1;
            checkOutput($sformatf("arb_grant%0d", t), g, (t % 2 == 0) ? 1 : 2);
            if (g == 1) begin
                sendW(1);
                getB(2'b00, 4'd3, $sformatf("arb_w%0d", t));
            end else if (g == 2) begin
                recvR(1, 1'b0);
                checkOutput($sformatf("arb_r%0d_data", t), rbuf[0], 64'h11);
                checkOutput($sformatf("arb_r%0d_rid", t), ridFirst, 4'd5);
            end
        end
        awvalid = 0; arvalid = 0;

        for (int i = 0; i < 3; i++) begin
            wbuf[i] = 64'hA0 + 64'(i); sbuf[i] = 8'hFF;
        end
        writeBurst(32'h600, 8'd2, 2'b00, "mid_fill");
        sendAw(32'h600, 8'd3, 3'd3, 2'd1, 4'd1);
        wbuf[0] = 64'h1111; wbuf[1] = 64'h2222;
        sendW(2);
        wvalid = 1; wdata = 64'h3333; wstrb = 8'hFF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_wready", wready, 0);
        checkOutput("mid_valids", {bvalid, rvalid, awready, arready, rlast}, 0);
        checkOutput("mid_rdata", rdata, 0);
        wvalid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_no_bvalid", bvalid, 0);
        readBurst(32'h600, 8'd2, 3'd3, 2'd1);
        checkOutput("mid_beat1", rbuf[0], 64'h1111);
        checkOutput("mid_beat2", rbuf[1], 64'h2222);
        checkOutput("mid_beat3", rbuf[2], 64'hA2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
